// File: rtl/ff256_mult_by_const_wb_master.sv
// Wishbone classic initiator for the GF(256) multiply-by-constant responder:
// writes a 64-bit job as two words, waits for the responder to settle, reads the product back.
module ff256_mult_by_const_wb_master #(
    parameter int BUS_WIDTH  = 1,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int SETTLE     = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    job_valid_i,
    output logic                    job_ready_o,
    input  logic [2*DATA_WIDTH-1:0] job_data_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [2*DATA_WIDTH-1:0] res_data_o,
    output logic                    res_err_o,
    output logic [BUS_WIDTH-1:0]    adr_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic                    we_o,
    output logic [BE_WIDTH-1:0]     sel_o,
    output logic                    stb_o,
    input  logic                    ack_i,
    output logic                    cyc_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR0    = 3'd1,
        S_WR1    = 3'd2,
        S_SETTLE = 3'd3,
        S_RD0    = 3'd4,
        S_RD1    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // One counter serves both the settle interval and the per-beat ack timeout.
    localparam int CNT_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0]   job_q, job_d;
    logic [2*DATA_WIDTH-1:0]   res_q, res_d;
    logic                      err_q, err_d;

    logic [DATA_WIDTH-1:0]     job_word [2];
    logic                      in_beat;
    logic                      ack_hit;
    logic                      beat_expired;
    logic                      settle_done;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_job_word
            assign job_word[gi] = job_q[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign in_beat      = (state_q == S_WR0) || (state_q == S_WR1) ||
                          (state_q == S_RD0) || (state_q == S_RD1);
    assign ack_hit      = in_beat && ack_i;
    assign beat_expired = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign settle_done  = (cnt_q == CNT_W'(SETTLE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            job_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            job_q   <= job_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        job_d   = job_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (job_valid_i) begin
                    job_d   = job_data_i;
                    res_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WR0;
                end
            end
            S_WR0, S_WR1, S_RD0, S_RD1: begin
                if (ack_hit) begin
                    cnt_d = '0;
                    case (state_q)
                        S_WR0:   state_d = S_WR1;
                        S_WR1:   state_d = S_SETTLE;
                        S_RD0: begin
                            res_d[DATA_WIDTH-1:0] = data_i;
                            state_d = S_RD1;
                        end
                        default: begin
                            res_d[2*DATA_WIDTH-1:DATA_WIDTH] = data_i;
                            state_d = S_DONE;
                        end
                    endcase
                end else if (beat_expired) begin
                    // Abandon the remaining beats; a partial read must not leak out.
                    cnt_d   = '0;
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (settle_done) begin
                    cnt_d   = '0;
                    state_d = S_RD0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        job_ready_o = 1'b0;
        res_valid_o = 1'b0;
        adr_o       = '0;
        data_o      = '0;
        we_o        = 1'b0;
        sel_o       = '0;
        stb_o       = 1'b0;
        cyc_o       = 1'b0;
        case (state_q)
            S_IDLE: job_ready_o = 1'b1;
            S_WR0: begin
                cyc_o  = 1'b1;
                stb_o  = 1'b1;
                sel_o  = '1;
                we_o   = 1'b1;
                data_o = job_word[0];
            end
            S_WR1: begin
                cyc_o  = 1'b1;
                stb_o  = 1'b1;
                sel_o  = '1;
                we_o   = 1'b1;
                adr_o  = BUS_WIDTH'(1);
                data_o = job_word[1];
            end
            S_SETTLE: cyc_o = 1'b1;
            S_RD0: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                sel_o = '1;
            end
            S_RD1: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                sel_o = '1;
                adr_o = BUS_WIDTH'(1);
            end
            S_DONE: res_valid_o = 1'b1;
            default: job_ready_o = 1'b0;
        endcase
    end

    assign res_data_o = res_q;
    assign res_err_o  = err_q;

endmodule

// File: doc/ff256_mult_by_const_wb_master.md
# ff256_mult_by_const_wb_master

Wishbone classic initiator that drives the GF(256) multiply-by-constant responder. It accepts a 64-bit job (eight input bytes) over a valid/ready port and performs two bus writes, to address 0 and then address 1. It waits a fixed settle interval, performs two bus reads from the same addresses, and returns the 64-bit product word (plus an error flag) over a valid/ready result port. It sits between a local datapath or CPU-side sequencer and the multiplier's Wishbone slave port.

## Interface
- BUS_WIDTH, 1, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; job/result width is 2*DATA_WIDTH.
- BE_WIDTH, 4, byte-select width.
- SETTLE, 2, idle cycles between the last write ack and the first read strobe (covers the responder's registered output); legal range ≥1.
- TIMEOUT, 15, maximum cycles a single beat may wait for ack_i; legal range ≥1.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- job_valid_i  in  1  job offered.
- job_ready_o  out  1  high only in IDLE.
- job_data_i  in  2*DATA_WIDTH  [31:0] → address 0, [63:32] → address 1.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  result consumer ready.
- res_data_o  out  2*DATA_WIDTH  [31:0] ← read of address 0, [63:32] ← read of address 1.
- res_err_o  out  1  ack timeout occurred on this job; qualified by res_valid_o.
- adr_o  out  BUS_WIDTH  Wishbone address.
- data_o  out  DATA_WIDTH  Wishbone write data.
- data_i  in  DATA_WIDTH  Wishbone read data.
- we_o  out  1  write enable.
- sel_o  out  BE_WIDTH  byte select.
- stb_o  out  1  strobe.
- ack_i  in  1  acknowledge.
- cyc_o  out  1  bus cycle.

## Operation
- States: IDLE, WR0, WR1, SETTLE, RD0, RD1, DONE.
- IDLE:
  - job_ready_o=1.
  - On job_valid_i & job_ready_o, latch job_data_i, clear the error flag, go to WR0.
- WR0: adr_o=0, we_o=1, data_o=job[31:0]. Ack → WR1.
- WR1: adr_o=1, we_o=1, data_o=job[63:32]. Ack → SETTLE.
- SETTLE:
  - stb_o=0, cyc_o=1.
  - Count SETTLE cycles, then go to RD0.
- RD0: adr_o=0, we_o=0. Ack → capture data_i into res[31:0], go to RD1.
- RD1: adr_o=1, we_o=0. Ack → capture data_i into res[63:32], go to DONE.
- DONE:
  - cyc_o=0, stb_o=0, res_valid_o=1.
  - Hold until res_ready_i; then go to IDLE (res_valid_o drops next cycle).
- In WR0/WR1/RD0/RD1: stb_o=1, cyc_o=1, sel_o all ones.
- Outside bus beats: stb_o=0, we_o=0, sel_o=0, data_o=0.
- cyc_o is high continuously from WR0 through RD1, including SETTLE.
- Ack is accepted only when sampled high at a rising edge while stb_o=1; ack_i with stb_o=0 is ignored.
- Back-to-back beats: stb_o stays high; adr_o/we_o/data_o change on the edge that samples the ack.
- Timeout:
  - A per-beat counter clears on beat entry and increments each cycle without ack.
  - Reaching TIMEOUT without ack → go to DONE with res_err_o=1 and res_data_o=0; the remaining beats are skipped.
- Reset (asynchronous, any state):
  - State returns to IDLE; the in-flight bus cycle is abandoned.
  - All outputs 0 except job_ready_o=1.

## Timing
- Reset values: job_ready_o=1; res_valid_o, res_err_o, res_data_o, adr_o, data_o, we_o, sel_o, stb_o, cyc_o all 0.
- Zero-wait ack, SETTLE=2, job accepted at edge E:
  - WR0 in cycle E+1.
  - WR1 in cycle E+2.
  - SETTLE in cycles E+3 and E+4.
  - RD0 in cycle E+5.
  - RD1 in cycle E+6.
  - res_valid_o=1 from cycle E+7.
- Each ack wait state adds one cycle to its beat.
- Timeout: stb_o is high for exactly TIMEOUT cycles; res_valid_o rises the following cycle.
- job_valid_i while busy is not accepted and has no effect.
- Result stays stable while res_valid_o=1 and res_ready_i=0.

## Test plan
- Zero-wait responder, job 64'h0807060504030201:
  - Bus writes adr0=32'h04030201, then adr1=32'h08070605.
  - Reads return 32'h01234567 then 32'hDEADBEEF → res_data_o=64'hDEADBEEF01234567, res_err_o=0, res_valid_o at E+7.
  - Check SETTLE gap: stb_o low for 2 cycles, cyc_o high.
- Responder inserts 3 wait states on each beat → res_valid_o at E+19; result correct; stb_o/adr_o/data_o stable during waits.
- Responder never acks WR1, TIMEOUT=15:
  - stb_o high for 15 cycles, then cyc_o=0.
  - res_valid_o=1, res_err_o=1, res_data_o=0, no reads issued.
- res_ready_i held low 10 cycles after completion → res_valid_o and data held stable; job_ready_o stays 0; a second job_valid_i is not accepted until after the handshake.
- Assert reset during RD0 → stb_o, cyc_o, res_valid_o are 0 immediately and job_ready_o=1; the next job completes normally.
- ack_i pulsed high during IDLE and SETTLE → no state change, and the result is unaffected.
